// File: rtl/cpu_pkg.sv
// Shared datapath defaults and register-index helpers for decode, issue and the register bank.
// Declarations only: no latency and no backpressure apply.
package cpu_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 32;

  function automatic int reg_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int REG_AW_DEF = $clog2(NUM_REGS_DEF);

  typedef logic [REG_AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with the reserve/write/flush priority and per-port busy flags.
// Busy is combinational from sel_r (0 cycles); updates land at the next posedge; no backpressure.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = reg_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic [AW-1:0]        sel_w,
  input  logic                 reserve,
  input  logic [AW-1:0]        sel_rsv,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] sel_r,
  output logic [NUM_RD-1:0]    busy
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // A retiring write clears first; a newer reservation to the same index overrides it.
  always_comb begin
    pending_d = pending_q;
    if (write) begin
      pending_d[sel_w] = 1'b0;
    end
    if (flush) begin
      pending_d = '0;
    end else if (reserve) begin
      pending_d[sel_rsv] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [AW-1:0] idx;
    logic          resolved;
    assign idx      = sel_r[i*AW +: AW];
    assign resolved = (BYPASS != 0) && write && (sel_w == idx);
    assign busy[i]  = pending_q[idx] && !resolved && !((ZERO_REG != 0) && (idx == '0));
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write forwarding and pending-write scoreboard.
// Reads are combinational (0 cycles), writes land at posedge; no internal stalls or backpressure.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = reg_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic [AW-1:0]            sel_w,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_RD*AW-1:0]     sel_r,
  output logic [NUM_RD*DATA_W-1:0] data_out,
  input  logic                     reserve,
  input  logic [AW-1:0]            sel_rsv,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        busy
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_en;
  logic              fwd_en;

  assign wr_en  = write && !((ZERO_REG != 0) && (sel_w == '0));
  // Forwarding is gated by reset so outputs stay all-zero while reset is held.
  assign fwd_en = (BYPASS != 0) && write && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_en) begin
      mem_q[sel_w] <= data_in;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = sel_r[i*AW +: AW];
    assign data_out[i*DATA_W +: DATA_W] =
        ((ZERO_REG != 0) && (idx == '0)) ? '0 :
        (fwd_en && (sel_w == idx))       ? data_in :
                                           mem_q[idx];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .sel_w   (sel_w),
    .reserve (reserve),
    .sel_rsv (sel_rsv),
    .flush   (flush),
    .sel_r   (sel_r),
    .busy    (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 4-port forwarding instance and a 2-port non-forwarding instance share write/reserve stimulus.
module tb_regfile_mp;

  logic         clk;
  logic         rst_n;
  logic         write;
  logic [4:0]   sel_w;
  logic [63:0]  data_in;
  logic         reserve;
  logic [4:0]   sel_rsv;
  logic         flush;
  logic [19:0]  sel_r_a;
  logic [255:0] data_out_a;
  logic [3:0]   busy_a;
  logic [9:0]   sel_r_b;
  logic [127:0] data_out_b;
  logic [1:0]   busy_b;

  int checks;
  int failures;

  regfile_mp #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .write(write), .sel_w(sel_w), .data_in(data_in),
    .sel_r(sel_r_a), .data_out(data_out_a), .reserve(reserve), .sel_rsv(sel_rsv),
    .flush(flush), .busy(busy_a)
  );

  regfile_mp #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .write(write), .sel_w(sel_w), .data_in(data_in),
    .sel_r(sel_r_b), .data_out(data_out_b), .reserve(reserve), .sel_rsv(sel_rsv),
    .flush(flush), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write   = 1'b0;
    reserve = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    write = 1'b1; sel_w = 5'd5; data_in = 64'hDEAD;
    reserve = 1'b1; sel_rsv = 5'd6;
    tick();
    idle();
    sel_r_a = {5'd0, 5'd0, 5'd6, 5'd5};
    #1;
    checks++;
    if (data_out_a[63:0] !== 64'hDEAD) begin
      failures++;
      $display("FAIL reset_pre_data got=%h want=%h", data_out_a[63:0], 64'hDEAD);
    end
    checks++;
    if (busy_a !== 4'b0010) begin
      failures++;
      $display("FAIL reset_pre_busy got=%b want=%b", busy_a, 4'b0010);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out_a !== 256'h0) begin
      failures++;
      $display("FAIL reset_held_data got=%h want=0", data_out_a);
    end
    checks++;
    if (busy_a !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held_busy got=%b want=0000", busy_a);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (data_out_a[63:0] !== 64'h0 || busy_a !== 4'b0000) begin
      failures++;
      $display("FAIL reset_after got=%h/%b want=0/0000", data_out_a[63:0], busy_a);
    end
  endtask

  task automatic test_bypass();
    idle();
    write = 1'b1; sel_w = 5'd3; data_in = 64'h1234;
    sel_r_a = {5'd0, 5'd0, 5'd0, 5'd3};
    sel_r_b = {5'd0, 5'd3};
    #1;
    checks++;
    if (data_out_a[63:0] !== 64'h1234) begin
      failures++;
      $display("FAIL bypass_fwd got=%h want=%h", data_out_a[63:0], 64'h1234);
    end
    checks++;
    if (data_out_b[63:0] !== 64'h0) begin
      failures++;
      $display("FAIL nobypass_old got=%h want=0", data_out_b[63:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (data_out_b[63:0] !== 64'h1234 || data_out_a[63:0] !== 64'h1234) begin
      failures++;
      $display("FAIL write_next_cycle got=%h/%h want=1234", data_out_a[63:0], data_out_b[63:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    write = 1'b1; sel_w = 5'd0; data_in = 64'hFFFF;
    sel_r_a = '0;
    #1;
    checks++;
    if (data_out_a !== 256'h0) begin
      failures++;
      $display("FAIL zero_bypass got=%h want=0", data_out_a);
    end
    tick();
    idle();
    reserve = 1'b1; sel_rsv = 5'd0;
    #1;
    checks++;
    if (data_out_a !== 256'h0) begin
      failures++;
      $display("FAIL zero_stored got=%h want=0", data_out_a);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_a !== 4'b0000) begin
      failures++;
      $display("FAIL zero_busy got=%b want=0000", busy_a);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    reserve = 1'b1; sel_rsv = 5'd7;
    tick();
    idle();
    sel_r_a = {5'd0, 5'd0, 5'd7, 5'd0};
    sel_r_b = {5'd7, 5'd0};
    #1;
    checks++;
    if (busy_a !== 4'b0010 || busy_b !== 2'b10) begin
      failures++;
      $display("FAIL sb_reserved got=%b/%b want=0010/10", busy_a, busy_b);
    end
    write = 1'b1; sel_w = 5'd7; data_in = 64'hABCD;
    #1;
    checks++;
    if (busy_a !== 4'b0000 || data_out_a[127:64] !== 64'hABCD) begin
      failures++;
      $display("FAIL sb_resolve got=%b/%h want=0000/abcd", busy_a, data_out_a[127:64]);
    end
    checks++;
    if (busy_b !== 2'b10) begin
      failures++;
      $display("FAIL sb_nobypass_busy got=%b want=10", busy_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_a !== 4'b0000 || busy_b !== 2'b00 || data_out_a[127:64] !== 64'hABCD) begin
      failures++;
      $display("FAIL sb_after got=%b/%b/%h want=0000/00/abcd", busy_a, busy_b, data_out_a[127:64]);
    end
  endtask

  task automatic test_collision_flush();
    idle();
    reserve = 1'b1; sel_rsv = 5'd9;
    write = 1'b1; sel_w = 5'd9; data_in = 64'h9999;
    tick();
    idle();
    sel_r_a = {5'd0, 5'd11, 5'd10, 5'd9};
    #1;
    checks++;
    if (busy_a !== 4'b0001 || data_out_a[63:0] !== 64'h9999) begin
      failures++;
      $display("FAIL collision got=%b/%h want=0001/9999", busy_a, data_out_a[63:0]);
    end
    flush = 1'b1; reserve = 1'b1; sel_rsv = 5'd10;
    write = 1'b1; sel_w = 5'd11; data_in = 64'hB11B;
    tick();
    idle();
    #1;
    checks++;
    if (busy_a !== 4'b0000) begin
      failures++;
      $display("FAIL flush_busy got=%b want=0000", busy_a);
    end
    checks++;
    if (data_out_a[191:128] !== 64'hB11B) begin
      failures++;
      $display("FAIL flush_write got=%h want=b11b", data_out_a[191:128]);
    end
  endtask

  task automatic test_multiport();
    idle();
    write = 1'b1; sel_w = 5'd1; data_in = 64'h11;
    tick();
    sel_w = 5'd2; data_in = 64'h22;
    tick();
    idle();
    sel_r_a = {5'd1, 5'd3, 5'd2, 5'd1};
    #1;
    checks++;
    if (data_out_a !== {64'h11, 64'h1234, 64'h22, 64'h11}) begin
      failures++;
      $display("FAIL multiport_read got=%h want=%h", data_out_a, {64'h11, 64'h1234, 64'h22, 64'h11});
    end
    write = 1'b1; sel_w = 5'd1; data_in = 64'h5555;
    #1;
    checks++;
    if (data_out_a !== {64'h5555, 64'h1234, 64'h22, 64'h5555}) begin
      failures++;
      $display("FAIL multiport_fwd got=%h want=%h", data_out_a, {64'h5555, 64'h1234, 64'h22, 64'h5555});
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    write = 1'b1; sel_w = 5'd4; data_in = 64'h4444;
    tick();
    sel_w = 5'd5; data_in = 64'h5A5A;
    sel_r_a = {5'd0, 5'd0, 5'd5, 5'd4};
    #1;
    checks++;
    if (data_out_a[127:0] !== {64'h5A5A, 64'h4444}) begin
      failures++;
      $display("FAIL back_to_back got=%h want=%h", data_out_a[127:0], {64'h5A5A, 64'h4444});
    end
    tick();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    write    = 1'b0;
    sel_w    = '0;
    data_in  = '0;
    reserve  = 1'b0;
    sel_rsv  = '0;
    flush    = 1'b0;
    sel_r_a  = '0;
    sel_r_b  = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision_flush();
    test_multiport();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write-through bypass and a per-register pending-write scoreboard. It is the next-generation register bank for the pipelined datapath: one write port and NUM_RD combinational read ports. A busy flag per read port tells issue logic when a source register still awaits an in-flight result. All state clears on asynchronous active-low reset.

## Interface
- DATA_W, 64: register width in bits.
- NUM_REGS, 32: register count; power of two, ≥2. AW = $clog2(NUM_REGS).
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- write  in  1  write enable for sel_w/data_in.
- sel_w  in  AW  write register index.
- data_in  in  DATA_W  write data.
- sel_r  in  NUM_RD*AW  read indices, port i at [i*AW +: AW].
- data_out  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
- reserve  in  1  mark sel_rsv pending (issued instruction will write it).
- sel_rsv  in  AW  register to reserve.
- flush  in  1  clear all pending bits (pipeline flush); data untouched.
- busy  out  NUM_RD  port i source is pending and not resolved this cycle.

## Operation
- Storage: NUM_REGS × DATA_W array plus NUM_REGS pending bits.
- Write: at posedge, if write and not (ZERO_REG and sel_w==0), reg[sel_w] <= data_in and pending[sel_w] <= 0.
- Read (combinational, every port independent):
  - ZERO_REG and sel_r_i==0 -> 0.
  - else BYPASS and write and sel_w==sel_r_i -> data_in.
  - else reg[sel_r_i].
- Reserve: at posedge, if reserve and not flush and not (ZERO_REG and sel_rsv==0), pending[sel_rsv] <= 1.
- Simultaneous write and reserve to the same index: reserve wins, pending stays 1, data is written. A newer producer supersedes the retiring one.
- Flush: at posedge, all pending bits cleared. Overrides reserve that cycle. Writes still complete.
- busy[i] = pending[sel_r_i] and not (BYPASS and write and sel_w==sel_r_i). With ZERO_REG, busy is 0 for index 0.
- Out-of-range indices cannot occur because NUM_REGS is a power of two.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all pending 0. data_out is therefore all-zero and busy is 0 while reset is held. A write or reserve asserted during reset is discarded.
- Read latency: 0 cycles, combinational from sel_r/reg/bypass inputs.
- Write visible through array reads the cycle after posedge, or the same cycle via bypass.
- Reserve visible on busy the cycle after posedge. The clear from a write is visible in the same cycle via the busy bypass term when BYPASS=1, and the next cycle when BYPASS=0.
- No handshake stalls inside the block. Issue logic must hold instructions while any used busy bit is 1.

## Structure
- Shared package cpu_pkg: DATA_W/NUM_REGS defaults and the function reg_aw(n) = $clog2(n). The register-index type lives there for use by decode and issue.
- Sub-module regfile_scoreboard: holds the pending bits, reserve/write/flush priority and the busy computation. Inputs are clk, rst_n, write, sel_w, reserve, sel_rsv, flush and sel_r; output is busy.
- The top level holds the data array, the read mux and the bypass, and instantiates the scoreboard once.

## Test plan
- Reset then read: assert rst_n=0 mid-cycle with reg5=0xDEAD previously written -> data_out immediately 0, busy 0; after release, a read of reg5 returns 0.
- Write/bypass: write=1, sel_w=3, data_in=0x1234, sel_r port0=3 in the same cycle -> port0=0x1234 at once (BYPASS=1); with BYPASS=0 it reads the old 0, and 0x1234 appears the next cycle.
- Zero register: write 0xFFFF to reg0, then read reg0 on all ports -> 0; reserve reg0 -> busy stays 0.
- Scoreboard: reserve reg7, next cycle sel_r port1=7 -> busy[1]=1; the cycle write=1 sel_w=7 -> busy[1]=0 and data_out=data_in; the following cycle busy stays 0.
- Collision/flush: same-cycle reserve and write on reg9 -> pending[9]=1 afterwards, reg9 holds the written data. Then flush together with reserve reg10 -> all busy 0, reg10 not pending.
- Multi-port: NUM_RD=4, read regs 1,2,3,1 with distinct stored values -> each port returns its own value; a write to reg1 forwards on ports 0 and 3 only.
